codec_startup_seq: RTL and testbench



---
 rtl/codec_startup_pkg.sv | 39 +++
 rtl/codec_startup_seq.sv | 190 +++++++++++++++++++
 tb/tb_codec_startup_seq.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/codec_startup_pkg.sv
// Shared types and constants for the CODEC start-up sequencer:
// state encoding, default cycle counts at 12 MHz, and the counter-width helper.
package codec_startup_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PDN_LOW    = 3'd1,
        PDN_SETTLE = 3'd2,
        INIT_WAIT  = 3'd3,
        UNMUTE     = 3'd4,
        RUN        = 3'd5,
        FAULT      = 3'd6
    } state_e;

    localparam int unsigned DEF_PDN_CYCLES    = 1200;
    localparam int unsigned DEF_SETTLE_CYCLES = 12000;
    localparam int unsigned DEF_INIT_TIMEOUT  = 1200000;
    localparam int unsigned DEF_UNMUTE_CYCLES = 120000;
    localparam int unsigned DEF_MAX_RETRIES   = 3;

    // A zero cycle count would make a timed state meaningless, so it means one cycle.
    function automatic int unsigned clamp1(input int unsigned v);
        return (v == 0) ? 1 : v;
    endfunction

    // One bit more than needed for the longest interval, so N-1 always fits.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c,
                                              input int unsigned d);
        int unsigned m;
        m = clamp1(a);
        if (clamp1(b) > m) m = clamp1(b);
        if (clamp1(c) > m) m = clamp1(c);
        if (clamp1(d) > m) m = clamp1(d);
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/codec_startup_seq.sv
// CODEC bring-up sequencer in the 12 MHz domain: power-down pulse, settle wait,
// I2C init handshake with timeout, unmute delay, then audio enable.
// One FSM shares a single down-counter across all timed states; every output
// is registered from the current state, so outputs lag the state by one cycle.
// Optional build macro CODEC_STARTUP_RETRY_EN: init failures re-power the CODEC
// up to MAX_RETRIES times before giving up in FAULT.
module codec_startup_seq
    import codec_startup_pkg::*;
#(
`ifdef CODEC_STARTUP_RETRY_EN
    parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES,
`endif
    parameter int unsigned PDN_CYCLES    = DEF_PDN_CYCLES,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned INIT_TIMEOUT  = DEF_INIT_TIMEOUT,
    parameter int unsigned UNMUTE_CYCLES = DEF_UNMUTE_CYCLES
) (
    input  logic       clk_12m,
    input  logic       rst_n,
    input  logic       restart,
    input  logic       init_done,
    input  logic       init_err,
    output logic       codec_pdn_n,
    output logic       init_req,
    output logic       audio_en,
    output logic       fault,
    output logic [2:0] state_o
);

    localparam int unsigned CW = cnt_width(PDN_CYCLES, SETTLE_CYCLES, INIT_TIMEOUT, UNMUTE_CYCLES);
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t PDN_LOAD    = cnt_t'(clamp1(PDN_CYCLES) - 1);
    localparam cnt_t SETTLE_LOAD = cnt_t'(clamp1(SETTLE_CYCLES) - 1);
    localparam cnt_t INIT_LOAD   = cnt_t'(clamp1(INIT_TIMEOUT) - 1);
    localparam cnt_t UNMUTE_LOAD = cnt_t'(clamp1(UNMUTE_CYCLES) - 1);

`ifdef CODEC_STARTUP_RETRY_EN
    localparam int unsigned MAXR_N = clamp1(MAX_RETRIES);
    localparam int unsigned RW     = $clog2(MAXR_N + 1);
    localparam logic [RW-1:0] MAXR_VAL = RW'(MAXR_N);

    logic [RW-1:0] retry_q, retry_d;
`endif

    state_e     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic       entry_q, entry_d;
    logic       init_fail;

    logic       pdn_q, pdn_d;
    logic       req_q, req_d;
    logic       audio_q, audio_d;
    logic       fault_q, fault_d;
    logic [2:0] state_out_q;

    // Next state, counter reload/decrement and the registered-output next values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        init_fail = 1'b0;
`ifdef CODEC_STARTUP_RETRY_EN
        retry_d   = retry_q;
`endif

        if (restart && (state_q != IDLE)) begin
            state_d = PDN_LOW;
            cnt_d   = PDN_LOAD;
`ifdef CODEC_STARTUP_RETRY_EN
            retry_d = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = PDN_LOW;
                    cnt_d   = PDN_LOAD;
                end
                PDN_LOW: begin
                    if (cnt_q == '0) begin
                        state_d = PDN_SETTLE;
                        cnt_d   = SETTLE_LOAD;
                    end else begin
                        cnt_d = cnt_q - cnt_t'(1);
                    end
                end
                PDN_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_d = INIT_WAIT;
                        cnt_d   = INIT_LOAD;
                    end else begin
                        cnt_d = cnt_q - cnt_t'(1);
                    end
                end
                INIT_WAIT: begin
                    if (init_err) begin
                        init_fail = 1'b1;
                    end else if (init_done) begin
                        state_d = UNMUTE;
                        cnt_d   = UNMUTE_LOAD;
                    end else if (cnt_q == '0) begin
                        init_fail = 1'b1;
                    end else begin
                        cnt_d = cnt_q - cnt_t'(1);
                    end
                end
                UNMUTE: begin
                    if (cnt_q == '0) begin
                        state_d = RUN;
                        cnt_d   = '0;
`ifdef CODEC_STARTUP_RETRY_EN
                        retry_d = '0;
`endif
                    end else begin
                        cnt_d = cnt_q - cnt_t'(1);
                    end
                end
                RUN, FAULT: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase

            if (init_fail) begin
`ifdef CODEC_STARTUP_RETRY_EN
                if (retry_q == MAXR_VAL) begin
                    state_d = FAULT;
                    cnt_d   = '0;
                end else begin
                    retry_d = retry_q + RW'(1);
                    state_d = PDN_LOW;
                    cnt_d   = PDN_LOAD;
                end
`else
                state_d = FAULT;
                cnt_d   = '0;
`endif
            end
        end

        entry_d = (state_d != state_q);
        pdn_d   = !((state_q == IDLE) || (state_q == PDN_LOW) || (state_q == FAULT));
        req_d   = (state_q == INIT_WAIT) && entry_q;
        audio_d = (state_q == RUN);
        fault_d = (state_q == FAULT);
    end

    // State, counter and output registers; reset forces everything back at once.
    always_ff @(posedge clk_12m) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            entry_q     <= 1'b0;
            pdn_q       <= 1'b0;
            req_q       <= 1'b0;
            audio_q     <= 1'b0;
            fault_q     <= 1'b0;
            state_out_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            entry_q     <= entry_d;
            pdn_q       <= pdn_d;
            req_q       <= req_d;
            audio_q     <= audio_d;
            fault_q     <= fault_d;
            state_out_q <= state_q;
        end
    end

`ifdef CODEC_STARTUP_RETRY_EN
    // Retry budget consumed by failed init attempts.
    always_ff @(posedge clk_12m) begin
        if (!rst_n) begin
            retry_q <= '0;
        end else begin
            retry_q <= retry_d;
        end
    end
`endif

    assign codec_pdn_n = pdn_q;
    assign init_req    = req_q;
    assign audio_en    = audio_q;
    assign fault       = fault_q;
    assign state_o     = state_out_q;

endmodule

// File: tb/tb_codec_startup_seq.sv
// Self-checking bench for codec_startup_seq with shortened cycle counts.
// A cycle-level reference model tracks the sequence by elapsed time in each
// phase; directed scenarios add hand-computed latency checks on top of it.
module tb_codec_startup_seq;

    localparam int PDN = 4;
    localparam int SET = 8;
    localparam int TO  = 16;
    localparam int UN  = 5;
`ifdef CODEC_STARTUP_RETRY_EN
    localparam int MAXR = 3;
`endif

    logic       clk_12m;
    logic       rst_n;
    logic       restart;
    logic       init_done;
    logic       init_err;
    logic       codec_pdn_n;
    logic       init_req;
    logic       audio_en;
    logic       fault;
    logic [2:0] state_o;

    int checkCount = 0;
    int passCount  = 0;

    codec_startup_seq #(
        .PDN_CYCLES   (PDN),
        .SETTLE_CYCLES(SET),
        .INIT_TIMEOUT (TO),
        .UNMUTE_CYCLES(UN)
    ) dut (
        .clk_12m    (clk_12m),
        .rst_n      (rst_n),
        .restart    (restart),
        .init_done  (init_done),
        .init_err   (init_err),
        .codec_pdn_n(codec_pdn_n),
        .init_req   (init_req),
        .audio_en   (audio_en),
        .fault      (fault),
        .state_o    (state_o)
    );

    initial clk_12m = 1'b0;
    always #5 clk_12m = ~clk_12m;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: phase number 0..6 and cycles already spent in that phase.
    int  ms;
    int  elapsed;
    int  retries;
    bit  valid = 0;
    bit  expPdn, expReq, expAudio, expFault;
    int  expState;

    always @(posedge clk_12m) begin : model
        int nxt;
        bit reload;
        bit failed;
        if (!rst_n) begin
            ms = 0; elapsed = 0; retries = 0;
            expPdn = 0; expReq = 0; expAudio = 0; expFault = 0; expState = 0;
            valid = 1;
        end else begin
            expPdn   = !(ms == 0 || ms == 1 || ms == 6);
            expReq   = (ms == 3) && (elapsed == 0);
            expAudio = (ms == 5);
            expFault = (ms == 6);
            expState = ms;
            nxt = ms; reload = 0; failed = 0;
            if (restart && ms != 0) begin
                nxt = 1; reload = 1; retries = 0;
            end else begin
                case (ms)
                    0: nxt = 1;
                    1: if (elapsed + 1 == PDN) nxt = 2;
                    2: if (elapsed + 1 == SET) nxt = 3;
                    3: begin
                        if (init_err) failed = 1;
                        else if (init_done) nxt = 4;
                        else if (elapsed + 1 == TO) failed = 1;
                    end
                    4: if (elapsed + 1 == UN) begin nxt = 5; retries = 0; end
                    default: ;
                endcase
                if (failed) begin
`ifdef CODEC_STARTUP_RETRY_EN
                    if (retries == MAXR) nxt = 6;
                    else begin retries++; nxt = 1; end
`else
                    nxt = 6;
`endif
                end
            end
            if (nxt != ms || reload) elapsed = 0;
            else elapsed++;
            ms = nxt;
        end
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clk_12m) begin
        if (valid) begin
            checkOutput("model_codec_pdn_n", codec_pdn_n, expPdn);
            checkOutput("model_init_req", init_req, expReq);
            checkOutput("model_audio_en", audio_en, expAudio);
            checkOutput("model_fault", fault, expFault);
            checkOutput("model_state_o", state_o, expState);
        end
    end

    task automatic step();
        @(posedge clk_12m);
        #1;
    endtask

    task automatic applyStimulus(input bit r, input bit d, input bit e);
        restart = r; init_done = d; init_err = e;
        step();
        restart = 0; init_done = 0; init_err = 0;
    endtask

    function automatic bit sig(input int sel);
        case (sel)
            0: return codec_pdn_n === 1'b1;
            1: return init_req === 1'b1;
            2: return audio_en === 1'b1;
            default: return fault === 1'b1;
        endcase
    endfunction

    task automatic waitFor(input int sel, input int budget, output int steps);
        bit found;
        found = 0;
        steps = 0;
        while (!found && steps < budget) begin
            step();
            steps++;
            if (sig(sel)) found = 1;
        end
        checkOutput($sformatf("wait_sig%0d_seen", sel), found, 1);
    endtask

    initial begin : stim
        int n;
        int lowCount;
        int reqPulses;
        rst_n = 0; restart = 0; init_done = 0; init_err = 0;
        repeat (3) step();

        checkOutput("reset_codec_pdn_n", codec_pdn_n, 0);
        checkOutput("reset_init_req", init_req, 0);
        checkOutput("reset_audio_en", audio_en, 0);
        checkOutput("reset_fault", fault, 0);
        checkOutput("reset_state_o", state_o, 0);

        // Nominal bring-up
        rst_n = 1;
        waitFor(0, 50, n);
        checkOutput("release_to_pdn_rise", n, 6);
        waitFor(1, 50, n);
        checkOutput("pdn_rise_to_init_req", n, 8);
        step();
        checkOutput("init_req_width", init_req, 0);
        step();
        applyStimulus(0, 1, 0);
        waitFor(2, 50, n);
        checkOutput("init_done_to_audio_en", n, 6);
        checkOutput("run_state_o", state_o, 5);

        // Stray handshake pulses in RUN are ignored
        applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 1);
        step();
        checkOutput("stray_pulse_state_o", state_o, 5);
        checkOutput("stray_pulse_audio_en", audio_en, 1);

        // Restart from RUN
        applyStimulus(1, 0, 0);
        checkOutput("audio_on_restart_edge", audio_en, 1);
        step();
        checkOutput("audio_drop_after_restart", audio_en, 0);
        lowCount = 0;
        while (codec_pdn_n !== 1'b1 && lowCount < 50) begin
            lowCount++;
            step();
        end
        checkOutput("pdn_low_after_restart", lowCount, 4);

        // Init timeout
        waitFor(1, 50, n);
        checkOutput("restart_pdn_to_init_req", n, 8);
        reqPulses = 1;
        n = 0;
        while (fault !== 1'b1 && n < 300) begin
            step();
            n++;
            if (init_req === 1'b1) reqPulses++;
        end
`ifdef CODEC_STARTUP_RETRY_EN
        checkOutput("timeout_to_fault_cycles", n, 100);
        checkOutput("init_req_pulses_before_fault", reqPulses, 4);
`else
        checkOutput("timeout_to_fault_cycles", n, 16);
        checkOutput("init_req_pulses_before_fault", reqPulses, 1);
`endif
        checkOutput("fault_codec_pdn_n", codec_pdn_n, 0);
        checkOutput("fault_audio_en", audio_en, 0);

        // Restart from FAULT clears fault
        applyStimulus(1, 0, 0);
        checkOutput("fault_on_restart_edge", fault, 1);
        step();
        checkOutput("fault_cleared_after_restart", fault, 0);

        // init_done and init_err together: error wins
        waitFor(1, 50, n);
        applyStimulus(0, 1, 1);
        step();
`ifdef CODEC_STARTUP_RETRY_EN
        checkOutput("done_err_same_cycle_state_o", state_o, 1);
`else
        checkOutput("done_err_same_cycle_state_o", state_o, 6);
`endif

        // init_done on the final timeout cycle: done wins
        applyStimulus(1, 0, 0);
        waitFor(1, 50, n);
        repeat (14) step();
        applyStimulus(0, 1, 0);
        step();
        checkOutput("done_on_expiry_state_o", state_o, 4);

        // Reset in the middle of UNMUTE
        rst_n = 0;
        step();
        checkOutput("midreset_codec_pdn_n", codec_pdn_n, 0);
        checkOutput("midreset_init_req", init_req, 0);
        checkOutput("midreset_audio_en", audio_en, 0);
        checkOutput("midreset_fault", fault, 0);
        checkOutput("midreset_state_o", state_o, 0);
        rst_n = 1;
        waitFor(0, 50, n);
        checkOutput("midreset_release_to_pdn_rise", n, 6);
        waitFor(1, 50, n);
        applyStimulus(0, 1, 0);
        waitFor(2, 50, n);
        checkOutput("second_run_done_to_audio_en", n, 6);
        repeat (3) step();

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
